// File: rtl/rggen_axi4lite_bridge_if.sv
// Request/response channel between the AXI4-Lite bridge and the register-block adapter.
// access: 2'b10 read, 2'b11 write; status: 0 OKAY, 1 EXOKAY, 2 SLAVE_ERROR, 3 DECODE_ERROR.
interface rggen_bus_if #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int BUS_WIDTH     = 32
);
   logic                     valid;
   logic [1:0]               access;
   logic [ADDRESS_WIDTH-1:0] address;
   logic [BUS_WIDTH-1:0]     write_data;
   logic [BUS_WIDTH/8-1:0]   strobe;
   logic                     ready;
   logic [1:0]               status;
   logic [BUS_WIDTH-1:0]     read_data;

   modport master (
      output valid, access, address, write_data, strobe,
      input  ready, status, read_data
   );

   modport slave (
      input  valid, access, address, write_data, strobe,
      output ready, status, read_data
   );
endinterface

// File: rtl/rggen_axi4lite_bridge.sv
// AXI4-Lite slave to rggen register bus bridge, one transaction in flight.
// Define RGGEN_AXI4LITE_WRITE_PRIORITY_EN to make writes always win over simultaneous reads.
module rggen_axi4lite_bridge #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int BUS_WIDTH     = 32
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_awvalid,
   output logic                     o_awready,
   input  logic [ADDRESS_WIDTH-1:0] i_awaddr,
   input  logic                     i_wvalid,
   output logic                     o_wready,
   input  logic [BUS_WIDTH-1:0]     i_wdata,
   input  logic [BUS_WIDTH/8-1:0]   i_wstrb,
   output logic                     o_bvalid,
   input  logic                     i_bready,
   output logic [1:0]               o_bresp,
   input  logic                     i_arvalid,
   output logic                     o_arready,
   input  logic [ADDRESS_WIDTH-1:0] i_araddr,
   output logic                     o_rvalid,
   input  logic                     i_rready,
   output logic [BUS_WIDTH-1:0]     o_rdata,
   output logic [1:0]               o_rresp,
   rggen_bus_if.master              bus_if
);
   localparam int STRB_W = BUS_WIDTH / 8;
   localparam logic [1:0] RGGEN_READ  = 2'b10;
   localparam logic [1:0] RGGEN_WRITE = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      BUS_ACCESS,
      RESPONSE
   } state_t;

   state_t                   state;
   state_t                   state_next;
   logic                     last_write;
   logic                     is_write;
   logic                     write_req;
   logic                     read_req;
   logic                     grant_write;
   logic                     grant_read;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [BUS_WIDTH-1:0]     wdata_q;
   logic [STRB_W-1:0]        strb_q;
   logic [1:0]               status_q;
   logic [BUS_WIDTH-1:0]     rdata_q;

   // A write needs both AW and W; a lone AW or W is never taken.
   always_comb begin
      write_req = i_awvalid && i_wvalid;
      read_req  = i_arvalid;
`ifdef RGGEN_AXI4LITE_WRITE_PRIORITY_EN
      grant_write = write_req;
`else
      grant_write = write_req && !(read_req && last_write);
`endif
      grant_read  = read_req && !grant_write;
   end

   always_comb begin
      state_next = state;
      o_awready  = 1'b0;
      o_wready   = 1'b0;
      o_arready  = 1'b0;
      o_bvalid   = 1'b0;
      o_rvalid   = 1'b0;
      o_bresp    = 2'b00;
      o_rresp    = 2'b00;
      o_rdata    = '0;
      case (state)
         IDLE: begin
            if (grant_write || grant_read) begin
               o_awready  = grant_write;
               o_wready   = grant_write;
               o_arready  = grant_read;
               state_next = BUS_ACCESS;
            end
         end
         BUS_ACCESS: begin
            if (bus_if.ready) begin
               state_next = RESPONSE;
            end
         end
         RESPONSE: begin
            if (is_write) begin
               o_bvalid = 1'b1;
               o_bresp  = status_q;
               if (i_bready) begin
                  state_next = IDLE;
               end
            end else begin
               o_rvalid = 1'b1;
               o_rresp  = status_q;
               o_rdata  = rdata_q;
               if (i_rready) begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         last_write <= 1'b0;
         is_write   <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE && (grant_write || grant_read)) begin
            is_write   <= grant_write;
            last_write <= grant_write;
         end
      end
   end

   // Datapath captures carry no reset; every output they reach is gated by state.
   always_ff @(posedge i_clk) begin
      if (state == IDLE && (grant_write || grant_read)) begin
         addr_q  <= grant_write ? i_awaddr : i_araddr;
         wdata_q <= grant_write ? i_wdata : '0;
         strb_q  <= grant_write ? i_wstrb : '1;
      end
      if (state == BUS_ACCESS && bus_if.ready) begin
         status_q <= bus_if.status;
         rdata_q  <= bus_if.read_data;
      end
   end

   assign bus_if.valid      = (state == BUS_ACCESS);
   assign bus_if.access     = is_write ? RGGEN_WRITE : RGGEN_READ;
   assign bus_if.address    = addr_q;
   assign bus_if.write_data = wdata_q;
   assign bus_if.strobe     = strb_q;
endmodule

// File: doc/rggen_axi4lite_bridge.md
RGGEN_AXI4LITE_BRIDGE -- requirements
Module: rggen_axi4lite_bridge

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, width of AXI and bus addresses.
REQ-002 SHALL have parameter BUS_WIDTH, default 32, data width; strobe width is BUS_WIDTH/8.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_awvalid  input  1  write address valid.
REQ-006 SHALL have port o_awready  output  1  write address ready.
REQ-007 SHALL have port i_awaddr  input  ADDRESS_WIDTH  write address.
REQ-008 SHALL have port i_wvalid  input  1  write data valid.
REQ-009 SHALL have port o_wready  output  1  write data ready.
REQ-010 SHALL have port i_wdata  input  BUS_WIDTH  write data.
REQ-011 SHALL have port i_wstrb  input  BUS_WIDTH/8  write byte strobes.
REQ-012 SHALL have port o_bvalid  output  1  write response valid.
REQ-013 SHALL have port i_bready  input  1  write response ready.
REQ-014 SHALL have port o_bresp  output  2  write response code.
REQ-015 SHALL have port i_arvalid  input  1  read address valid.
REQ-016 SHALL have port o_arready  output  1  read address ready.
REQ-017 SHALL have port i_araddr  input  ADDRESS_WIDTH  read address.
REQ-018 SHALL have port o_rvalid  output  1  read data valid.
REQ-019 SHALL have port i_rready  input  1  read data ready.
REQ-020 SHALL have port o_rdata  output  BUS_WIDTH  read data.
REQ-021 SHALL have port o_rresp  output  2  read response code.
REQ-022 SHALL have port bus_if  rggen_bus_if.master  -  request/response toward the register-block adapter.

Function
REQ-023 SHALL implement FSM IDLE -> BUS_ACCESS -> RESPONSE -> IDLE; one transaction in flight.
REQ-024 In IDLE, write request = i_awvalid && i_wvalid; AW or W alone SHALL NOT be accepted.
REQ-025 In IDLE, selected request SHALL get ready high combinationally (o_awready+o_wready, or o_arready); address/data/strobe/access captured; next state BUS_ACCESS.
REQ-026 BUS_ACCESS: bus_if.valid=1, access RGGEN_WRITE/RGGEN_READ, address/write_data/strobe from capture registers, held stable until bus_if.ready; read drives strobe all-ones.
REQ-027 On bus_if.ready in BUS_ACCESS: capture bus_if.status and bus_if.read_data, go RESPONSE next cycle.
REQ-028 RESPONSE: o_bvalid (write) or o_rvalid (read) high, o_bresp/o_rresp = 2-bit rggen_status encoding unchanged; o_rdata = captured data, stable while valid; on bready/rready go IDLE.
REQ-029 Minimum latency: handshake cycle N, bus_if.valid N+1, o_bvalid/o_rvalid N+2 when bus_if.ready immediate.
REQ-030 Read and write pending same cycle: round-robin, grant opposite of last-served type; last-served resets to read.
REQ-031 All ready outputs SHALL be low outside IDLE; o_rdata SHALL be zero for write transactions.

Reset
REQ-032 On i_rst_n low: state IDLE, last-served read, all valid/ready outputs 0, o_bresp/o_rresp/o_rdata 0, bus_if.valid 0; in-flight transaction discarded with no response.

Configuration
REQ-033 With RGGEN_AXI4LITE_WRITE_PRIORITY_EN defined, simultaneous requests SHALL always grant write; undefined, REQ-030 round-robin applies.

Verification
REQ-034 Write 0x10 data 0xA5A5A5A5 strb 0xF, bus ready immediate status OKAY -> bus valid 1 cycle, o_bvalid 2 cycles after handshake, bresp 0.
REQ-035 Read 0x20, bus ready after 3 wait cycles, read_data 0x12345678 status SLAVE_ERROR -> address held 4 cycles, o_rdata 0x12345678, rresp 2.
REQ-036 i_awvalid high, i_wvalid low 5 cycles -> o_awready stays 0, no bus access; accepted when i_wvalid rises.
REQ-037 AW/W and AR valid together twice after reset -> write first then read (round-robin); with macro, write both times.
REQ-038 i_rready low 4 cycles in RESPONSE -> o_rvalid/o_rdata stable, no new handshake; reset asserted during BUS_ACCESS -> all outputs 0 next edge-free.
